// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_port_arbiter_if                                            |
// | Brief    : Fetch, data and SRAM-side signal bundle for sram_port_arbiter.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_gnt;
    logic                  inst_rvalid;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_rready;
    logic                  stall_if;

    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_rready;

    logic                  sram_en;
    logic [DATA_W/8-1:0]   sram_wen;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_rready,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata, data_rready,
        input  sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata, stall_if,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    // Requester pipeline plus SRAM macro side.
    modport master (
        output inst_req, inst_addr, inst_rready,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata, data_rready,
        output sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata, stall_if,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_port_arbiter                                               |
// | Brief    : Shares one single-port SRAM between fetch and data ports, with  |
// |            per-port read-data hold buffers. SRAM_ARB_STARVE_GUARD_EN adds  |
// |            a fetch anti-starvation counter (default: strict data priority).|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               resetn,
    sram_port_arbiter_if.slave bus
);
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_INST = 2'd1;
    localparam logic [1:0] c_OWN_DATA = 2'd2;
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_HELD  = 1'b1;

    logic [1:0]             r_pend;
    logic [1:0]             w_rvalid;
    logic [1:0]             w_rready;
    logic [1:0]             w_mine;
    logic [1:0][DATA_W-1:0] w_rdata;
    logic                   w_inst_elig;
    logic                   w_data_elig;
    logic                   w_inst_win;
    logic                   w_data_win;
    logic                   w_force_inst;

    assign w_rready = {bus.data_rready, bus.inst_rready};
    assign w_mine   = {r_pend == c_OWN_DATA, r_pend == c_OWN_INST};

    // A response slot is free when nothing is presented or it is consumed now.
    assign w_inst_elig = bus.inst_req && (!w_rvalid[0] || w_rready[0]);
    assign w_data_elig = bus.data_req && (bus.data_wr || !w_rvalid[1] || w_rready[1]);

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int                 c_CNT_W   = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_force_inst = (r_starve_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (bus.inst_req && !w_inst_win) begin
            if (r_starve_cnt != c_CNT_MAX) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`else
    // Fetch is never forced through; the expression only ties off STARVE_MAX.
    assign w_force_inst = (STARVE_MAX < 0);
`endif

    always_comb begin
        w_inst_win = 1'b0;
        w_data_win = 1'b0;
        if (resetn) begin
            if (w_inst_elig && w_data_elig) begin
                w_inst_win = w_force_inst;
                w_data_win = !w_force_inst;
            end else begin
                w_inst_win = w_inst_elig;
                w_data_win = w_data_elig;
            end
        end
    end

    always_comb begin
        bus.sram_en    = w_inst_win || w_data_win;
        bus.sram_wen   = '0;
        bus.sram_addr  = {ADDR_W{1'b0}};
        bus.sram_wdata = '0;
        if (w_data_win) begin
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
            if (bus.data_wr) begin
                bus.sram_wen = bus.data_wstrb;
            end
        end else if (w_inst_win) begin
            bus.sram_addr = bus.inst_addr;
        end
    end

    assign bus.inst_gnt = w_inst_win;
    assign bus.data_gnt = w_data_win;
    assign bus.stall_if = bus.inst_req && !w_inst_win;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= c_OWN_NONE;
        end else if (w_inst_win) begin
            r_pend <= c_OWN_INST;
        end else if (w_data_win && !bus.data_wr) begin
            r_pend <= c_OWN_DATA;
        end else begin
            r_pend <= c_OWN_NONE;
        end
    end

    // Index 0 is the fetch response path, index 1 the data response path.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        logic [0:0]        r_state;
        logic [0:0]        w_state_nxt;
        logic [DATA_W-1:0] r_hold;
        logic              w_rv;
        logic [DATA_W-1:0] w_rd;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_state <= c_ST_EMPTY;
                r_hold  <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (r_state == c_ST_EMPTY && w_mine[gi] && !w_rready[gi]) begin
                    r_hold <= bus.sram_rdata;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_ST_EMPTY: if (w_mine[gi] && !w_rready[gi]) w_state_nxt = c_ST_HELD;
                default:    if (w_rready[gi])                w_state_nxt = c_ST_EMPTY;
            endcase
        end

        always_comb begin
            w_rv = 1'b0;
            w_rd = '0;
            if (resetn) begin
                case (r_state)
                    c_ST_EMPTY: begin
                        w_rv = w_mine[gi];
                        w_rd = bus.sram_rdata;
                    end
                    default: begin
                        w_rv = 1'b1;
                        w_rd = r_hold;
                    end
                endcase
            end
        end

        assign w_rvalid[gi] = w_rv;
        assign w_rdata[gi]  = w_rd;
    end

    assign bus.inst_rvalid = w_rvalid[0];
    assign bus.inst_rdata  = w_rdata[0];
    assign bus.data_rvalid = w_rvalid[1];
    assign bus.data_rdata  = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_port_arbiter                                            |
// | Brief    : Self-checking bench: vector table, directed corner sequences    |
// |            and random traffic against a queue-based reference model.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sram_port_arbiter;
    localparam int STARVE_MAX = 3;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each port has a queue of read words awaiting delivery.
    logic [31:0] mq_i[$];
    logic [31:0] mq_d[$];
    bit          mp_i, mp_d;
    int          m_den;

    // DUT outputs sampled in the most recent cycle.
    logic        s_ig, s_dg, s_stall, s_en, s_irv, s_drv;
    logic [3:0]  s_wen;
    logic [31:0] s_addr, s_wdata, s_ird, s_drd, s_srd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          rv_i, rv_d, ie, de, ig, dg;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wen;
        @(negedge clk);
        if (!resetn) begin
            mq_i.delete(); mq_d.delete();
            mp_i = 0; mp_d = 0; m_den = 0;
        end else begin
            if (mp_i) mq_i.push_back(bus.sram_rdata);
            if (mp_d) mq_d.push_back(bus.sram_rdata);
        end
        rv_i = (mq_i.size() > 0);
        rv_d = (mq_d.size() > 0);
        ie = resetn && bus.inst_req && (!rv_i || bus.inst_rready);
        de = resetn && bus.data_req && (bus.data_wr || !rv_d || bus.data_rready);
        ig = 0; dg = 0;
        if (ie && de) begin
            if (GUARD && m_den == STARVE_MAX) ig = 1; else dg = 1;
        end else begin
            ig = ie; dg = de;
        end
        e_addr  = dg ? bus.data_addr : (ig ? bus.inst_addr : 32'h0);
        e_wdata = dg ? bus.data_wdata : 32'h0;
        e_wen   = (dg && bus.data_wr) ? bus.data_wstrb : 4'h0;

        s_ig = bus.inst_gnt;   s_dg = bus.data_gnt;   s_stall = bus.stall_if;
        s_en = bus.sram_en;    s_wen = bus.sram_wen;  s_addr = bus.sram_addr;
        s_wdata = bus.sram_wdata;
        s_irv = bus.inst_rvalid; s_ird = bus.inst_rdata;
        s_drv = bus.data_rvalid; s_drd = bus.data_rdata;
        s_srd = bus.sram_rdata;

        chk("inst_gnt", s_ig, ig);
        chk("data_gnt", s_dg, dg);
        chk("stall_if", s_stall, bus.inst_req && !ig);
        chk("sram_en", s_en, ig || dg);
        chk("sram_wen", s_wen, e_wen);
        chk("sram_addr", s_addr, e_addr);
        chk("sram_wdata", s_wdata, e_wdata);
        chk("inst_rvalid", s_irv, rv_i);
        chk("data_rvalid", s_drv, rv_d);
        if (rv_i) chk("inst_rdata", s_ird, mq_i[0]);
        if (rv_d) chk("data_rdata", s_drd, mq_d[0]);
        if (!resetn) begin
            chk("inst_rdata_rst", s_ird, 0);
            chk("data_rdata_rst", s_drd, 0);
        end

        if (resetn) begin
            if (rv_i && bus.inst_rready) void'(mq_i.pop_front());
            if (rv_d && bus.data_rready) void'(mq_d.pop_front());
            mp_i = ig;
            mp_d = dg && !bus.data_wr;
            if (bus.inst_req && !ig) m_den = (m_den < STARVE_MAX) ? m_den + 1 : STARVE_MAX;
            else                     m_den = 0;
        end
        @(posedge clk);
        #1;
        bus.sram_rdata = $urandom;
    endtask

    task automatic set_idle();
        bus.inst_req = 0; bus.inst_addr = 0; bus.inst_rready = 1;
        bus.data_req = 0; bus.data_wr = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0; bus.data_rready = 1;
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq, dwr;
        logic [3:0]  strb;
        logic [31:0] daddr, dwdata;
        logic        e_ig, e_dg, e_stall, e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    vec_t vecs[7];
    bit   i_act, d_act;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h0};
        vecs[1] = '{1, 32'hbfc00000, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 1, 4'h0, 32'hbfc00000, 32'h0};
        vecs[2] = '{0, 32'h0,        1, 0, 4'hf, 32'h40,  32'h55aa55aa, 0, 1, 0, 1, 4'h0, 32'h40,       32'h55aa55aa};
        vecs[3] = '{0, 32'h0,        1, 1, 4'h3, 32'h100, 32'haabbccdd, 0, 1, 0, 1, 4'h3, 32'h100,      32'haabbccdd};
        vecs[4] = '{1, 32'hbfc00004, 1, 0, 4'h0, 32'h200, 32'h0,        0, 1, 1, 1, 4'h0, 32'h200,      32'h0};
        vecs[5] = '{1, 32'hbfc00008, 1, 1, 4'hc, 32'h300, 32'h11223344, 0, 1, 1, 1, 4'hc, 32'h300,      32'h11223344};
        vecs[6] = '{1, 32'hbfc0000c, 0, 1, 4'hf, 32'h400, 32'hdeadbeef, 1, 0, 0, 1, 4'h0, 32'hbfc0000c, 32'h0};

        // Reset state, with a fetch request pending during reset.
        set_idle();
        bus.sram_rdata = 32'h0;
        bus.inst_req = 1; bus.data_req = 1;
        cycle();
        chk("rst_stall", s_stall, 1);
        chk("rst_gnt", {s_ig, s_dg}, 0);
        chk("rst_en", s_en, 0);
        chk("rst_rvalid", {s_irv, s_drv}, 0);
        resetn = 1;
        set_idle();
        cycle();

        for (int v = 0; v < 7; v++) begin
            bus.inst_req = vecs[v].ireq;   bus.inst_addr = vecs[v].iaddr;
            bus.data_req = vecs[v].dreq;   bus.data_wr = vecs[v].dwr;
            bus.data_wstrb = vecs[v].strb; bus.data_addr = vecs[v].daddr;
            bus.data_wdata = vecs[v].dwdata;
            cycle();
            chk("vec_inst_gnt", s_ig, vecs[v].e_ig);
            chk("vec_data_gnt", s_dg, vecs[v].e_dg);
            chk("vec_stall", s_stall, vecs[v].e_stall);
            chk("vec_en", s_en, vecs[v].e_en);
            chk("vec_wen", s_wen, vecs[v].e_wen);
            chk("vec_addr", s_addr, vecs[v].e_addr);
            chk("vec_wdata", s_wdata, vecs[v].e_wdata);
            set_idle();
            cycle();
            set_idle();
            cycle();
        end

        // Fetch-only streaming.
        for (int k = 0; k < 5; k++) begin
            bus.inst_req = 1; bus.inst_addr = 32'hbfc00000 + 32'(4 * k);
            cycle();
            chk("fetch_gnt", s_ig, 1);
            chk("fetch_stall", s_stall, 0);
            if (k > 0) begin
                chk("fetch_rvalid", s_irv, 1);
                chk("fetch_rdata", s_ird, s_srd);
            end
        end
        set_idle();
        cycle();
        chk("fetch_last_rvalid", s_irv, 1);
        chk("fetch_last_rdata", s_ird, s_srd);
        cycle();

        // Collision.
        bus.inst_req = 1; bus.inst_addr = 32'hbfc00010;
        bus.data_req = 1; bus.data_addr = 32'h20;
        cycle();
        chk("coll_data_gnt", s_dg, 1);
        chk("coll_inst_gnt", s_ig, 0);
        chk("coll_stall", s_stall, 1);
        bus.data_req = 0;
        cycle();
        chk("coll_data_rvalid", s_drv, 1);
        chk("coll_data_rdata", s_drd, s_srd);
        chk("coll_inst_gnt_next", s_ig, 1);
        set_idle();
        cycle();
        cycle();

        // Starvation: fetch wins every STARVE_MAX+1 cycles only with the guard.
        for (int k = 0; k < 8; k++) begin
            bus.inst_req = 1; bus.inst_addr = 32'hbfc00020;
            bus.data_req = 1; bus.data_addr = 32'h300;
            cycle();
            chk("starve_inst_gnt", s_ig, GUARD && (k % 4 == 3));
        end
        set_idle();
        cycle();
        cycle();

        // Backpressure on the data port.
        bus.data_req = 1; bus.data_addr = 32'h80;
        cycle();
        chk("bp_gnt_first", s_dg, 1);
        bus.sram_rdata = 32'h12345678;
        bus.data_rready = 0;
        bus.data_wr = 1; bus.data_wstrb = 4'hf; bus.data_addr = 32'h84; bus.data_wdata = 32'h0badf00d;
        cycle();
        chk("bp_write_gnt", s_dg, 1);
        chk("bp_rvalid_t1", s_drv, 1);
        chk("bp_rdata_t1", s_drd, 32'h12345678);
        bus.data_wr = 0; bus.data_addr = 32'h88;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("bp_read_blocked", s_dg, 0);
            chk("bp_rvalid_held", s_drv, 1);
            chk("bp_rdata_held", s_drd, 32'h12345678);
        end
        bus.data_rready = 1;
        cycle();
        chk("bp_drain_gnt", s_dg, 1);
        chk("bp_drain_rdata", s_drd, 32'h12345678);
        set_idle();
        cycle();
        chk("bp_next_rvalid", s_drv, 1);
        chk("bp_next_rdata", s_drd, s_srd);
        cycle();

        // Write: same-cycle access, no response beat.
        bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'b0011;
        bus.data_addr = 32'h100; bus.data_wdata = 32'haabbccdd;
        cycle();
        chk("wr_en", s_en, 1);
        chk("wr_wen", s_wen, 4'b0011);
        chk("wr_gnt", s_dg, 1);
        set_idle();
        cycle();
        chk("wr_no_rvalid", s_drv, 0);

        // Reset in the response cycle of a read, then starvation restarts from zero.
        for (int k = 0; k < 2; k++) begin
            bus.inst_req = 1; bus.inst_addr = 32'hbfc00040;
            bus.data_req = 1; bus.data_addr = 32'h500;
            cycle();
        end
        resetn = 0;
        cycle();
        chk("rstmid_drvalid", s_drv, 0);
        chk("rstmid_gnt", {s_ig, s_dg}, 0);
        chk("rstmid_stall", s_stall, 1);
        resetn = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (k == 0) chk("rstmid_after_rvalid", {s_irv, s_drv}, 0);
            chk("rstmid_starve_gnt", s_ig, GUARD && (k == 3));
        end
        set_idle();
        cycle();
        cycle();

        // Random traffic; requests stay stable until granted.
        i_act = 0; d_act = 0;
        for (int k = 0; k < 500; k++) begin
            if (!i_act || s_ig) begin
                i_act = ($urandom_range(0, 3) != 0);
                bus.inst_addr = $urandom;
            end
            if (!d_act || s_dg) begin
                d_act = ($urandom_range(0, 4) != 0);
                bus.data_wr = ($urandom_range(0, 2) == 0);
                bus.data_wstrb = 4'($urandom);
                bus.data_addr = $urandom;
                bus.data_wdata = $urandom;
            end
            bus.inst_req = i_act;
            bus.data_req = d_act;
            bus.inst_rready = ($urandom_range(0, 3) != 0);
            bus.data_rready = ($urandom_range(0, 3) != 0);
            resetn = ($urandom_range(0, 99) != 0);
            cycle();
        end
        resetn = 1;
        set_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
